shift_unit: RTL and testbench
=============================

# shift_unit

Parametrised, multi-cycle shift/rotate engine for the datapath ALU. It extends the single-position byte shifter to WIDTH bits and to shift amounts greater than one. A shift runs as an iterative sequence of single-position (optionally four-position) steps under a start/busy/done handshake. It also adds arithmetic shift-right and a carry-out of the last bit shifted out.

## Interface
Parameters:
- WIDTH, 8: data width in bits; must be ≥ 4.
- AMT_W, 4: width of the shift-amount port; amounts 0..2^AMT_W-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only when busy=0.
- din  in  WIDTH  operand, sampled on accept.
- mode  in  3  operation, sampled on accept.
- amount  in  AMT_W  shift count, sampled on accept.
- dout  out  WIDTH  result; valid from the done cycle until the next accept.
- carry  out  1  last bit shifted/rotated out; 0 if no step was performed.
- busy  out  1  high while steps are in progress.
- done  out  1  one-cycle pulse marking a valid result.

## Operation
Mode encodings (shared package):
- 0 SHL fill 0
- 1 ROL
- 2 SHR fill 0
- 3 ROR
- 4 PASS
- 5 SHL fill 1
- 6 SHR fill 1
- 7 SAR (fill with the MSB)

State machine:
- IDLE:
  - On start, load the work register with din, the counter with amount and carry with 0; latch mode.
  - Go to DONE if amount=0 or mode=PASS; otherwise go to RUN.
- RUN (busy=1):
  - Each cycle, apply one step to the work register, set carry to the bit shifted out and decrement the counter.
  - When the counter reaches 0, go to DONE.
- DONE (done=1, busy=0):
  - Return to IDLE.
  - A start in DONE is accepted exactly as in IDLE.
- Amounts ≥ WIDTH are not clamped; steps repeat.
  - Shifts fill completely.
  - Rotates wrap modulo WIDTH.
  - SAR saturates to all copies of the sign bit.
- start while busy=1 is ignored; no queueing.
- dout follows the work register; it is meaningful only from done onward and holds until the next accept.

## Timing
- Reset values: dout=0, carry=0, busy=0, done=0, state IDLE.
- Reset mid-operation aborts immediately; no done is produced.
- Accept at edge E:
  - busy is high from E+1 through E+N, where N = amount.
  - done is high in the cycle after edge E+N+1.
  - Latency from accept to done is N+1 edges.
- amount=0 or PASS: done is high after E+1 with dout=din and carry=0.
- Back-to-back: start held high in the DONE cycle begins the next operation with no idle cycle.

## Configuration
Macro: SHIFT_UNIT_STEP4_EN.
- Defined:
  - In RUN, when counter ≥ 4, apply a four-position step and subtract 4; otherwise apply a single-position step.
  - carry is the last of the bits leaving in that step.
  - RUN length becomes floor(N/4) + (N mod 4) cycles.
- Undefined: single-position steps only; RUN length is N cycles.
- Results and carry are identical in both builds; only latency differs.

## Structure
- Package shift_pkg: mode encoding constants (SH_SHL0 … SH_SAR) and the state enum (IDLE/RUN/DONE).
- Sub-module shift_step: combinational, parametrised by WIDTH and STEP (1 or 4).
  - Inputs: data and mode. Outputs: shifted data and bit out.
  - Instantiated once per step size.
- shift_unit holds the FSM, counter, work register and carry register.

## Test plan
- Reset: assert rst with WIDTH=8 → dout=0x00, carry=0, busy=0, done=0. Deassert → stays in IDLE.
- SHL0 with din=0x81, amount=1 → busy for 1 cycle, then done; dout=0x02, carry=1.
- ROR with din=0x01, amount=3 → busy for 3 cycles; dout=0x20, carry=0.
- SAR with din=0x90, amount=2 → dout=0xE4, carry=0.
- SHR fill-1 with din=0x00, amount=9 → dout=0xFF, carry=1.
- PASS with din=0x5A, amount=5 → done one edge after accept, dout=0x5A, carry=0.
- Rejection and abort:
  - A second start during busy is ignored.
  - rst pulsed mid-RUN → no done pulse, and outputs return to their reset values.
- SHL0 with din=0x01, amount=7 → dout=0x80, carry=0.
  - Busy 4 cycles with SHIFT_UNIT_STEP4_EN defined.
  - Busy 7 cycles without it.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate engine: operation encodings and FSM states.
package shift_pkg;

    localparam logic [2:0] SH_SHL0 = 3'd0;
    localparam logic [2:0] SH_ROL  = 3'd1;
    localparam logic [2:0] SH_SHR0 = 3'd2;
    localparam logic [2:0] SH_ROR  = 3'd3;
    localparam logic [2:0] SH_PASS = 3'd4;
    localparam logic [2:0] SH_SHL1 = 3'd5;
    localparam logic [2:0] SH_SHR1 = 3'd6;
    localparam logic [2:0] SH_SAR  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Left-moving operations shift bits out of the MSB end.
    function automatic logic is_left(input logic [2:0] mode);
        return (mode == SH_SHL0) || (mode == SH_ROL) || (mode == SH_SHL1);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step of STEP positions for every operation mode.
// bit_out is the last bit leaving the word in this step (0 for PASS).
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             bit_out
);

    logic                     fill;
    logic [WIDTH+STEP-1:0]    ext_l;
    logic [WIDTH+STEP-1:0]    ext_r;
    logic [2*WIDTH-1:0]       dbl;

    always_comb begin
        fill = 1'b0;
        case (mode)
            SH_SHL1, SH_SHR1: fill = 1'b1;
            SH_SAR:           fill = data[WIDTH-1];
            default:          fill = 1'b0;
        endcase

        ext_l = {data, {STEP{fill}}};
        ext_r = {{STEP{fill}}, data};
        dbl   = {data, data};

        result  = data;
        bit_out = 1'b0;
        case (mode)
            SH_SHL0, SH_SHL1: begin
                result  = ext_l[WIDTH-1:0];
                bit_out = data[WIDTH-STEP];
            end
            SH_ROL: begin
                result  = dbl[2*WIDTH-STEP-1:WIDTH-STEP];
                bit_out = data[WIDTH-STEP];
            end
            SH_SHR0, SH_SHR1, SH_SAR: begin
                result  = ext_r[WIDTH+STEP-1:STEP];
                bit_out = data[STEP-1];
            end
            SH_ROR: begin
                result  = dbl[WIDTH+STEP-1:STEP];
                bit_out = data[STEP-1];
            end
            default: begin
                result  = data;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate engine with start/busy/done handshake.
// Optional macro SHIFT_UNIT_STEP4_EN enables four-position steps while the counter is >= 4.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one step per cycle, counter decrementing (busy=1)
// DONE  | result valid, done pulse; a start here is accepted as in IDLE
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] dout,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] cnt;
    logic [AMT_W-1:0] cnt_step;
    logic             carry_q;
    logic [2:0]       mode_q;
    logic             accept;

    logic [WIDTH-1:0] res1;
    logic             out1;
    logic [WIDTH-1:0] step_res;
    logic             step_out;

    shift_step #(.WIDTH(WIDTH), .STEP(1)) u_step1 (
        .data    (work),
        .mode    (mode_q),
        .result  (res1),
        .bit_out (out1)
    );

`ifdef SHIFT_UNIT_STEP4_EN
    logic [WIDTH-1:0] res4;
    logic             out4;
    logic             use4;

    shift_step #(.WIDTH(WIDTH), .STEP(4)) u_step4 (
        .data    (work),
        .mode    (mode_q),
        .result  (res4),
        .bit_out (out4)
    );

    always_comb begin
        use4     = (int'(cnt) >= 4);
        step_res = use4 ? res4 : res1;
        step_out = use4 ? out4 : out1;
        cnt_step = use4 ? (cnt - AMT_W'(4)) : (cnt - AMT_W'(1));
    end
`else
    always_comb begin
        step_res = res1;
        step_out = out1;
        cnt_step = cnt - AMT_W'(1);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ((amount == '0) || (mode == SH_PASS)) ? DONE : RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_step == '0) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work    <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            mode_q  <= SH_SHL0;
        end else if (accept) begin
            work    <= din;
            cnt     <= amount;
            carry_q <= 1'b0;
            mode_q  <= mode;
        end else if (state == RUN) begin
            work    <= step_res;
            carry_q <= step_out;
            cnt     <= cnt_step;
        end
    end

    assign dout  = work;
    assign carry = carry_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed self-checking bench for shift_unit (WIDTH=8, AMT_W=4), both step builds.
module tb_shift_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic [2:0] mode;
    logic [3:0] amount;
    logic [7:0] dout;
    logic       carry;
    logic       busy;
    logic       done;

    int vectors    = 0;
    int miscompares = 0;

    shift_unit #(.WIDTH(8), .AMT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .din    (din),
        .mode   (mode),
        .amount (amount),
        .dout   (dout),
        .carry  (carry),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_busy(input int n);
`ifdef SHIFT_UNIT_STEP4_EN
        return n / 4 + n % 4;
`else
        return n;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, count busy cycles, and stop at the negedge where done is seen.
    task automatic run_op(input string tag, input logic [2:0] m, input logic [7:0] d,
                          input logic [3:0] a, input logic [7:0] ed, input logic ec,
                          input int eb);
        int nb;
        logic got;
        @(negedge clk);
        start = 1'b1; mode = m; din = d; amount = a;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) nb++;
                @(negedge clk);
            end
        end
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " busy_cycles"}, 32'(nb), 32'(eb));
        check({tag, " dout"}, 32'(dout), 32'(ed));
        check({tag, " carry"}, 32'(carry), 32'(ec));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int nb;
        logic seen;
        rst = 1'b1; start = 1'b0; din = '0; mode = '0; amount = '0;
        repeat (3) @(negedge clk);
        check("rst dout", 32'(dout), 32'h00);
        check("rst carry", 32'(carry), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);
        check("idle done", 32'(done), 32'd0);

        run_op("shl0_81_1", 3'd0, 8'h81, 4'd1, 8'h02, 1'b1, exp_busy(1));
        run_op("ror_01_3",  3'd3, 8'h01, 4'd3, 8'h20, 1'b0, exp_busy(3));
        run_op("sar_90_2",  3'd7, 8'h90, 4'd2, 8'hE4, 1'b0, exp_busy(2));
        run_op("shr1_00_9", 3'd6, 8'h00, 4'd9, 8'hFF, 1'b1, exp_busy(9));
        run_op("pass_5a_5", 3'd4, 8'h5A, 4'd5, 8'h5A, 1'b0, 0);
        run_op("shl0_3c_0", 3'd0, 8'h3C, 4'd0, 8'h3C, 1'b0, 0);
        run_op("shl0_01_7", 3'd0, 8'h01, 4'd7, 8'h80, 1'b0, exp_busy(7));
        run_op("shl1_00_3", 3'd5, 8'h00, 4'd3, 8'h07, 1'b0, exp_busy(3));
        run_op("rol_80_9",  3'd1, 8'h80, 4'd9, 8'h01, 1'b1, exp_busy(9));
        run_op("sar_7f_15", 3'd7, 8'h7F, 4'd15, 8'h00, 1'b0, exp_busy(15));
        run_op("shr0_c0_6", 3'd2, 8'hC0, 4'd6, 8'h03, 1'b0, exp_busy(6));

        // Back-to-back: start held in the done cycle begins the next op without idling.
        start = 1'b1; mode = 3'd1; din = 8'h81; amount = 4'd1;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("b2b done", 32'(done), 32'd1);
        check("b2b dout", 32'(dout), 32'h03);
        check("b2b carry", 32'(carry), 32'd1);

        // A start while busy must be ignored.
        @(negedge clk);
        start = 1'b1; mode = 3'd0; din = 8'h01; amount = 4'd3;
        @(negedge clk);
        start = 1'b1; mode = 3'd2; din = 8'hFF; amount = 4'd1;
        @(negedge clk);
        start = 1'b0;
        nb = 1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nb++;
                @(negedge clk);
            end
        end
        check("ign done_seen", 32'(seen), 32'd1);
        check("ign busy_cycles", 32'(nb), 32'(exp_busy(3)));
        check("ign dout", 32'(dout), 32'h08);
        check("ign carry", 32'(carry), 32'd0);

        // Reset mid-RUN aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; mode = 3'd1; din = 8'hA5; amount = 4'd14;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort pre busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort dout", 32'(dout), 32'h00);
        check("abort carry", 32'(carry), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        check("abort no_done", 32'(seen), 32'd0);

        run_op("post_abort", 3'd3, 8'h03, 4'd1, 8'h81, 1'b1, exp_busy(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
